imem_arbiter: RTL and testbench

- Owns the single-port synchronous instruction memory (1-cycle read latency) and shares it between two requesters: the fetch stage (read-only) and the program loader/debug port (read/write).
- After reset, holds fetch in stall (BOOT) until the loader signals the program image is complete.
- In normal running, arbitrates per cycle with fetch priority, plus a starvation guard so the loader always makes progress.

---
 rtl/imem_arbiter.sv | 133 +++++++++++++
 tb/tb_imem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: owns the single-port synchronous instruction memory and
// shares it between the fetch stage (read-only) and the program loader
// (read/write). Fetch is held stalled in BOOT until the loader signals the
// image is complete. In RUN, fetch has per-cycle priority, and a starvation
// counter forces one loader cycle (FORCE) after STARVE_MAX denied cycles.
//
// Handshake: a requester holds req (and its address/data) while stalled.
// An access happens in the cycle its grant is high (fetch: fetch_req &
// ~fetch_stall, loader: ld_grant). Read data returns exactly one cycle
// later as a single-cycle valid pulse; there is no backpressure on returns.
module imem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_stall,
  output logic [DATA_W-1:0] fetch_inst,
  output logic              fetch_valid,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_done,
  output logic              ld_grant,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic              boot_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  localparam logic [1:0] TAG_NONE  = 2'd0;
  localparam logic [1:0] TAG_FETCH = 2'd1;
  localparam logic [1:0] TAG_LOAD  = 2'd2;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] starve_cnt;
  logic [7:0] starve_nxt;
  logic [1:0] tag;
  logic [1:0] tag_nxt;
  logic       fetch_gnt;
  logic       ld_gnt;

  // Per-cycle arbitration, starvation counting and next-state selection.
  always_comb begin
    fetch_gnt  = 1'b0;
    ld_gnt     = 1'b0;
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      ST_BOOT: begin
        ld_gnt     = ld_req;
        starve_nxt = 8'd0;
        if (ld_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        fetch_gnt = fetch_req;
        ld_gnt    = ld_req & ~fetch_req;
        if (ld_gnt) begin
          starve_nxt = 8'd0;
        end else if (ld_req) begin
          starve_nxt = starve_cnt + 8'd1;
          // Counter clears in FORCE, so it can never pass the limit and wrap.
          if (starve_nxt >= STARVE_LIM) state_nxt = ST_FORCE;
        end
      end
      ST_FORCE: begin
        ld_gnt     = ld_req;
        starve_nxt = 8'd0;
        state_nxt  = ST_RUN;
      end
      default: begin
        state_nxt  = ST_BOOT;
        starve_nxt = 8'd0;
      end
    endcase
  end

  // The read-owner tag follows whichever read was granted this cycle.
  always_comb begin
    tag_nxt = TAG_NONE;
    if (fetch_gnt)            tag_nxt = TAG_FETCH;
    else if (ld_gnt && !ld_we) tag_nxt = TAG_LOAD;
  end

  // State, counter, read-owner tag and boot flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      starve_cnt <= 8'd0;
      tag        <= TAG_NONE;
      boot_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      tag        <= tag_nxt;
      if (state == ST_BOOT && ld_done) boot_done <= 1'b1;
    end
  end

  // Memory port: the granted requester drives the address; only loader writes.
  always_comb begin
    mem_addr = fetch_gnt ? fetch_addr : ld_addr;
    mem_wren = ld_gnt & ld_we;
    mem_data = ld_wdata;
  end

  // Requester-facing outputs; read data is steered by last cycle's tag.
  always_comb begin
    fetch_stall = (state == ST_BOOT) | (fetch_req & ~fetch_gnt);
    ld_grant    = ld_gnt;
    fetch_valid = (tag == TAG_FETCH);
    ld_rvalid   = (tag == TAG_LOAD);
    fetch_inst  = fetch_valid ? mem_q : '0;
    ld_rdata    = ld_rvalid ? mem_q : '0;
    dbg_state   = state;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: a behavioural synchronous RAM sits on the
// mem_* port, a shadow copy of memory predicts read data, and expected
// returns are queued when a grant is expected and popped on valid pulses.
module tb_imem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SMAX = 4;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  logic          clk;
  logic          rst_n;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_stall;
  logic [DW-1:0] fetch_inst;
  logic          fetch_valid;
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_done;
  logic          ld_grant;
  logic [DW-1:0] ld_rdata;
  logic          ld_rvalid;
  logic          boot_done;
  logic [AW-1:0] mem_addr;
  logic          mem_wren;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q;
  logic [1:0]    dbg_state;

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_inst(fetch_inst), .fetch_valid(fetch_valid),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_grant(ld_grant), .ld_rdata(ld_rdata),
    .ld_rvalid(ld_rvalid), .boot_done(boot_done),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_data(mem_data),
    .mem_q(mem_q), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM, one-cycle read latency.
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr[7:0]] <= mem_data;
    mem_q <= ram[mem_addr[7:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] fexp_q[$];
  logic [DW-1:0] lexp_q[$];
  logic fv_pend = 1'b0;
  logic lv_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the returns owed from the previous cycle.
  task automatic check_returns();
    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, fv_pend});
    if (fetch_valid) begin
      if (fexp_q.size() == 0) check("fetch_q_underflow", 32'(fexp_q.size()), 32'd1);
      else check("fetch_inst", {16'd0, fetch_inst}, {16'd0, fexp_q.pop_front()});
    end
    check("ld_rvalid", {31'd0, ld_rvalid}, {31'd0, lv_pend});
    if (ld_rvalid) begin
      if (lexp_q.size() == 0) check("ld_q_underflow", 32'(lexp_q.size()), 32'd1);
      else check("ld_rdata", {16'd0, ld_rdata}, {16'd0, lexp_q.pop_front()});
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; drives one cycle, checks at the falling
  // edge, records expected returns, and returns just after the next edge.
  task automatic do_cycle(input logic fr, input logic [AW-1:0] fa,
                          input logic lr, input logic lwe,
                          input logic [AW-1:0] la, input logic [DW-1:0] lwd,
                          input logic done, input logic exp_fstall,
                          input logic exp_lgrant);
    logic fgnt;
    fetch_req = fr; fetch_addr = fa;
    ld_req = lr; ld_we = lwe; ld_addr = la; ld_wdata = lwd; ld_done = done;
    @(negedge clk);
    check_returns();
    check("fetch_stall", {31'd0, fetch_stall}, {31'd0, exp_fstall});
    check("ld_grant", {31'd0, ld_grant}, {31'd0, exp_lgrant});
    check("mem_wren", {31'd0, mem_wren}, {31'd0, exp_lgrant & lwe});
    fgnt = fr & ~exp_fstall;
    if (fgnt) check("mem_addr_fetch", {16'd0, mem_addr}, {16'd0, fa});
    else if (exp_lgrant) check("mem_addr_ld", {16'd0, mem_addr}, {16'd0, la});
    if (exp_lgrant && lwe) check("mem_data", {16'd0, mem_data}, {16'd0, lwd});
    fv_pend = fgnt;
    if (fgnt) fexp_q.push_back(ref_mem[fa[7:0]]);
    lv_pend = exp_lgrant & ~lwe;
    if (exp_lgrant && !lwe) lexp_q.push_back(ref_mem[la[7:0]]);
    if (exp_lgrant && lwe) ref_mem[la[7:0]] = lwd;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    logic lg;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
    rst_n = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ld_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fetch_stall", {31'd0, fetch_stall}, 32'd1);
    check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_ld_rvalid", {31'd0, ld_rvalid}, 32'd0);
    check("rst_boot_done", {31'd0, boot_done}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_BOOT});
    check("rst_mem_wren", {31'd0, mem_wren}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Boot: loader writes while fetch requests and stays stalled.
    do_cycle(1'b1, 16'd0, 1'b1, 1'b1, 16'd0, 16'h1111, 1'b0, 1'b1, 1'b1);
    do_cycle(1'b1, 16'd0, 1'b1, 1'b1, 16'd1, 16'h2222, 1'b0, 1'b1, 1'b1);
    for (int a = 2; a < 8; a++) begin
      d = 16'($urandom_range(0, 16'hFFFF));
      do_cycle(1'b1, 16'd0, 1'b1, 1'b1, 16'(a), d, 1'b0, 1'b1, 1'b1);
    end
    do_cycle(1'b1, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0);
    check("boot_done_after", {31'd0, boot_done}, 32'd1);
    check("state_run", {30'd0, dbg_state}, {30'd0, ST_RUN});

    // First fetch in RUN, then a loader read in an idle fetch gap.
    do_cycle(1'b1, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 16'd0, 1'b1, 1'b0, 16'd1, 16'd0, 1'b0, 1'b0, 1'b1);

    // Fetch priority: both request for fewer cycles than the starve limit.
    for (int i = 0; i < 3; i++)
      do_cycle(1'b1, 16'(i), 1'b1, 1'b0, 16'd1, 16'd0, 1'b0, 1'b0, 1'b0);

    // Write then fetch of the same address on the next cycle.
    do_cycle(1'b0, 16'd0, 1'b1, 1'b1, 16'd5, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    do_cycle(1'b1, 16'd5, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);

    // Starvation: both held, loader forced every SMAX+1 cycles.
    for (int i = 0; i < 3 * (SMAX + 1); i++) begin
      lg = ((i % (SMAX + 1)) == SMAX);
      do_cycle(1'b1, 16'($urandom_range(0, 7)), 1'b1, 1'b0, 16'd1, 16'd0,
               1'b0, lg, lg);
    end
    do_cycle(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    check("fetch_q_drained", 32'(fexp_q.size()), 32'd0);
    check("ld_q_drained", 32'(lexp_q.size()), 32'd0);

    // Async reset with a fetch read in flight.
    fetch_req = 1'b1; fetch_addr = 16'd2;
    @(negedge clk);
    check_returns();
    check("inflight_stall", {31'd0, fetch_stall}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", {30'd0, dbg_state}, {30'd0, ST_BOOT});
    check("arst_fetch_stall", {31'd0, fetch_stall}, 32'd1);
    check("arst_boot_done", {31'd0, boot_done}, 32'd0);
    fetch_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    fv_pend = 1'b0;
    lv_pend = 1'b0;
    @(negedge clk);
    check("arst_no_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("arst_no_ld_rvalid", {31'd0, ld_rvalid}, 32'd0);
    @(posedge clk);
    #1;
    do_cycle(1'b1, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    check("boot_again_done", {31'd0, boot_done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
